// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan scheduler feeding one shared seg7 decoder across NUM_DIGITS digits,
// with per-digit code storage, programmable dwell and a dark gap between digits.
module seg7_scan_ctrl #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned DEAD_CYCLES = 2,
  parameter int unsigned DEFAULT_DIV = 16000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [$clog2(NUM_DIGITS)-1:0] wr_idx,
  input  logic [3:0]                    wr_value,
  input  logic [15:0]                   div_in,
  input  logic                          update_div,
  output logic [3:0]                    seg_code,
  output logic [NUM_DIGITS-1:0]         digit_sel,
  output logic                          blank
);

  localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
  localparam int unsigned DIV_W  = 16;
  localparam int unsigned DEAD_W = 4;
  localparam int unsigned CODE_W = 4;

  typedef enum logic [1:0] {IDLE, SHOW, DEAD} state_t;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    scan_idx, scan_nxt;
  logic [DIV_W-1:0]    div_q, div_nxt;
  logic [DIV_W-1:0]    dwell_cnt, dwell_nxt;
  logic [DEAD_W-1:0]   dead_cnt, dead_nxt;
  logic [CODE_W-1:0]   regs     [NUM_DIGITS];
  logic [CODE_W-1:0]   regs_nxt [NUM_DIGITS];
  logic                wr_en;
  logic [NUM_DIGITS-1:0] sel_nxt;
  logic [CODE_W-1:0]   code_nxt;
  logic                blank_nxt;

  // The digit on display is frozen for its whole dwell; out-of-range indices never match scan_idx.
  assign wr_ready = !reset && !(state == SHOW && scan_idx == wr_idx);
  assign wr_en    = wr_valid && wr_ready && (32'(wr_idx) < NUM_DIGITS);

  // Next-state, storage update and next-output decode.
  always_comb begin
    state_nxt = state;
    scan_nxt  = scan_idx;
    dwell_nxt = dwell_cnt;
    dead_nxt  = dead_cnt;
    div_nxt   = div_q;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      regs_nxt[i] = regs[i];
      if (wr_en && wr_idx == IDX_W'(i)) regs_nxt[i] = wr_value;
    end

    if (update_div) begin
      div_nxt   = (div_in == '0) ? DIV_W'(1) : div_in;
      scan_nxt  = '0;
      dwell_nxt = '0;
      dead_nxt  = '0;
      state_nxt = enable ? SHOW : IDLE;
    end else if (!enable) begin
      state_nxt = IDLE;
      scan_nxt  = '0;
      dwell_nxt = '0;
      dead_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = SHOW;
          scan_nxt  = '0;
          dwell_nxt = '0;
          dead_nxt  = '0;
        end
        SHOW: begin
          if (dwell_cnt == div_q - DIV_W'(1)) begin
            state_nxt = DEAD;
            dwell_nxt = '0;
          end else begin
            dwell_nxt = dwell_cnt + DIV_W'(1);
          end
        end
        DEAD: begin
          if (dead_cnt == DEAD_W'(DEAD_CYCLES - 1)) begin
            state_nxt = SHOW;
            dead_nxt  = '0;
            scan_nxt  = (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
          end else begin
            dead_nxt = dead_cnt + DEAD_W'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    sel_nxt   = '0;
    code_nxt  = 4'hF;
    blank_nxt = 1'b1;
    if (state_nxt == SHOW) begin
      sel_nxt   = NUM_DIGITS'(1) << scan_nxt;
      code_nxt  = regs_nxt[scan_nxt];
      blank_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      scan_idx  <= '0;
      dwell_cnt <= '0;
      dead_cnt  <= '0;
      div_q     <= DIV_W'(DEFAULT_DIV);
      for (int i = 0; i < int'(NUM_DIGITS); i++) regs[i] <= 4'hF;
      digit_sel <= '0;
      seg_code  <= 4'hF;
      blank     <= 1'b1;
    end else begin
      state     <= state_nxt;
      scan_idx  <= scan_nxt;
      dwell_cnt <= dwell_nxt;
      dead_cnt  <= dead_nxt;
      div_q     <= div_nxt;
      for (int i = 0; i < int'(NUM_DIGITS); i++) regs[i] <= regs_nxt[i];
      digit_sel <= sel_nxt;
      seg_code  <= code_nxt;
      blank     <= blank_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a frame-position model predicts every cycle's outputs,
// a monitor process pops and compares them against the DUT.
module tb_seg7_scan_ctrl;

  localparam int N    = 4;
  localparam int DEAD = 2;
  localparam int DEF  = 16000;
  localparam int IW   = $clog2(N);

  typedef struct {
    logic [N-1:0] sel;
    logic [3:0]   code;
    logic         blank;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [IW-1:0] wr_idx = '0;
  logic [3:0]    wr_value = '0;
  logic [15:0]   div_in = '0;
  logic          update_div = 1'b0;
  logic [3:0]    seg_code;
  logic [N-1:0]  digit_sel;
  logic          blank;

  seg7_scan_ctrl #(.NUM_DIGITS(N), .DEAD_CYCLES(DEAD), .DEFAULT_DIV(DEF)) dut (
    .clk(clk), .reset(reset), .enable(enable), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_idx(wr_idx), .wr_value(wr_value), .div_in(div_in), .update_div(update_div),
    .seg_code(seg_code), .digit_sel(digit_sel), .blank(blank)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t oq[$];
  bit   rq[$];

  // Reference model: scanning is a position t since the last (re)start within repeating frames.
  bit         m_active = 1'b0;
  int         m_t = 0;
  int         m_div = DEF;
  logic [3:0] m_regs [N];

  function automatic bit m_show();
    return m_active && ((m_t % (m_div + DEAD)) < m_div);
  endfunction

  function automatic int m_digit();
    return (m_t / (m_div + DEAD)) % N;
  endfunction

  task automatic step();
    bit   rdy;
    exp_t e;
    rdy = !reset && !(m_show() && m_digit() == int'(wr_idx));
    rq.push_back(rdy);
    if (reset) begin
      m_active = 1'b0;
      m_t = 0;
      m_div = DEF;
      for (int i = 0; i < N; i++) m_regs[i] = 4'hF;
    end else begin
      if (wr_valid && rdy && int'(wr_idx) < N) m_regs[wr_idx] = wr_value;
      if (update_div) begin
        m_div = (div_in == 16'd0) ? 1 : int'(div_in);
        m_active = enable;
        m_t = 0;
      end else if (!enable) begin
        m_active = 1'b0;
        m_t = 0;
      end else if (!m_active) begin
        m_active = 1'b1;
        m_t = 0;
      end else begin
        m_t++;
      end
    end
    e.sel = '0;
    e.code = 4'hF;
    e.blank = 1'b1;
    if (m_show()) begin
      e.sel = N'(1) << m_digit();
      e.code = m_regs[m_digit()];
      e.blank = 1'b0;
    end
    oq.push_back(e);
    @(negedge clk);
    #1;
    cyc++;
  endtask

  // Bounded wait: kind 0 = dark gap while scanning, kind 1 = showing digit d.
  task automatic wait_for(input int kind, input int d, input int bound, input string what);
    int n;
    bit hit;
    n = 0;
    hit = (kind == 0) ? (m_active && !m_show()) : (m_show() && m_digit() == d);
    while (!hit && n < bound) begin
      step();
      n++;
      hit = (kind == 0) ? (m_active && !m_show()) : (m_show() && m_digit() == d);
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL wait_%s cyc=%0d: condition not reached in %0d cycles", what, cyc, bound);
    end
  endtask

  // Monitor: registered outputs at the falling edge, combinational wr_ready after inputs settle.
  initial begin
    exp_t e;
    bit   r;
    forever begin
      @(negedge clk);
      if (oq.size() > 0) begin
        e = oq.pop_front();
        checks += 3;
        if (digit_sel !== e.sel) begin
          failures++;
          $display("FAIL digit_sel cyc=%0d got=%b exp=%b", cyc, digit_sel, e.sel);
        end
        if (seg_code !== e.code) begin
          failures++;
          $display("FAIL seg_code cyc=%0d got=%h exp=%h", cyc, seg_code, e.code);
        end
        if (blank !== e.blank) begin
          failures++;
          $display("FAIL blank cyc=%0d got=%b exp=%b", cyc, blank, e.blank);
        end
      end
      #2;
      if (rq.size() > 0) begin
        r = rq.pop_front();
        checks++;
        if (wr_ready !== r) begin
          failures++;
          $display("FAIL wr_ready cyc=%0d got=%b exp=%b", cyc, wr_ready, r);
        end
      end
    end
  end

  initial begin
    bit acc;
    for (int i = 0; i < N; i++) m_regs[i] = 4'hF;
    @(negedge clk);
    #1;

    // Reset, then scan with the default dwell and no writes.
    repeat (2) step();
    reset = 1'b0;
    enable = 1'b1;
    repeat (DEF + DEAD + 6) step();

    // Load codes while idle, then a 3-cycle dwell.
    enable = 1'b0;
    step();
    for (int i = 0; i < N; i++) begin
      wr_valid = 1'b1;
      wr_idx = IW'(i);
      wr_value = 4'(i + 1);
      step();
    end
    wr_valid = 1'b0;
    update_div = 1'b1;
    div_in = 16'd3;
    enable = 1'b1;
    step();
    update_div = 1'b0;
    repeat (45) step();

    // Held write to the digit on display waits for its dark gap.
    wait_for(1, 2, 40, "show2");
    wr_valid = 1'b1;
    wr_idx = IW'(2);
    wr_value = 4'd7;
    acc = 1'b0;
    for (int n = 0; n < 10 && !acc; n++) begin
      step();
      acc = (m_regs[2] == 4'd7);
    end
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL held_write cyc=%0d got=not_accepted exp=accepted", cyc);
    end
    wr_valid = 1'b0;
    repeat (25) step();

    // Zero divisor mid-frame behaves as a 1-cycle dwell.
    repeat (7) step();
    update_div = 1'b1;
    div_in = 16'd0;
    step();
    update_div = 1'b0;
    repeat (30) step();

    // Enable dropped in the dark gap, then during a dwell.
    update_div = 1'b1;
    div_in = 16'd4;
    step();
    update_div = 1'b0;
    wait_for(0, 0, 20, "dead");
    enable = 1'b0;
    step();
    enable = 1'b1;
    repeat (20) step();
    wait_for(1, 1, 30, "show1");
    enable = 1'b0;
    step();
    enable = 1'b1;
    repeat (20) step();

    // Reset mid-dwell with a write attempt, then the default dwell again.
    update_div = 1'b1;
    div_in = 16'd5;
    step();
    update_div = 1'b0;
    wait_for(1, 1, 30, "show1b");
    step();
    reset = 1'b1;
    wr_valid = 1'b1;
    wr_idx = IW'(3);
    wr_value = 4'd5;
    step();
    reset = 1'b0;
    wr_valid = 1'b0;
    repeat (DEF + DEAD + 6) step();

    // Randomized traffic with short dwells.
    update_div = 1'b1;
    div_in = 16'd2;
    step();
    for (int n = 0; n < 3000; n++) begin
      wr_valid = 1'($urandom_range(0, 1));
      wr_idx = IW'($urandom_range(0, N - 1));
      wr_value = 4'($urandom_range(0, 15));
      update_div = ($urandom_range(0, 99) == 0);
      div_in = 16'($urandom_range(0, 5));
      enable = ($urandom_range(0, 49) != 0);
      step();
    end
    wr_valid = 1'b0;
    update_div = 1'b0;
    enable = 1'b1;
    repeat (5) step();

    @(negedge clk);
    #3;
    checks++;
    if (oq.size() != 0 || rq.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d/%0d pending exp=0/0", oq.size(), rq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
